// File: rtl/au_norm_pipe.sv
// Two-stage pipelined left-normalizer with valid/ready on both sides.
// Ports: clk, rst | in_valid/in_ready/in_data | out_valid/out_ready/out_data/out_shift/out_zero.
module au_norm_pipe #(
  parameter int WIDTH = 8,
  parameter int SW    = 4,
  parameter int ARCH  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]    out_shift,
  output logic             out_zero
);

  if (SW != $clog2(WIDTH + 1)) begin : g_bad_sw
    $error("au_norm_pipe: SW must equal clog2(WIDTH+1)");
  end
  if (ARCH < 0 || ARCH > 2) begin : g_bad_arch
    $error("au_norm_pipe: ARCH must be 0..2");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("au_norm_pipe: WIDTH must be >= 2");
  end

  // r is in_data bit-reversed so index j equals the leading-zero
  // count a '1' at that position would produce.
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] pre;
  logic [WIDTH-1:0] oh;
  logic [SW-1:0]    lz;

  always_comb begin
    r = '0;
    for (int j = 0; j < WIDTH; j++) begin
      r[j] = in_data[WIDTH-1-j];
    end
  end

  // pre[j] = |r[j:0], built by the selected prefix network.
  if (ARCH == 0) begin : g_ripple
    always_comb begin : p_ripple
      logic [WIDTH-1:0] t;
      t = r;
      for (int j = 1; j < WIDTH; j++) begin
        t[j] = t[j] | t[j-1];
      end
      pre = t;
    end
  end else if (ARCH == 1) begin : g_kogge
    always_comb begin : p_kogge
      logic [WIDTH-1:0] t;
      logic [WIDTH-1:0] n;
      t = r;
      n = r;
      for (int s = 1; s < WIDTH; s = s * 2) begin
        n = t;
        for (int j = s; j < WIDTH; j++) begin
          n[j] = t[j] | t[j-s];
        end
        t = n;
      end
      pre = t;
    end
  end else begin : g_sklansky
    // In-place update is safe: the source index of each level
    // has that level's bit clear and is not rewritten in it.
    always_comb begin : p_sklansky
      logic [WIDTH-1:0] t;
      t = r;
      for (int k = 0; (1 << k) < WIDTH; k++) begin
        for (int j = 0; j < WIDTH; j++) begin
          if ((j & (1 << k)) != 0) begin
            t[j] = t[j] | t[((j >> k) << k) - 1];
          end
        end
      end
      pre = t;
    end
  end

  always_comb begin
    oh    = '0;
    oh[0] = r[0];
    for (int j = 1; j < WIDTH; j++) begin
      oh[j] = r[j] & ~pre[j-1];
    end
  end

  // One-hot to binary; OR-reduction is exact since at most one bit is set.
  always_comb begin
    lz = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if (oh[j]) begin
        lz = lz | SW'(j);
      end
    end
    if (!pre[WIDTH-1]) begin
      lz = SW'(WIDTH);
    end
  end

  logic             v1;
  logic             v2;
  logic [WIDTH-1:0] d1;
  logic [SW-1:0]    lz1;
  logic             s1_load;
  logic             s2_load;

  assign s2_load   = !v2 || out_ready;
  assign s1_load   = !v1 || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = v2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      d1        <= '0;
      lz1       <= '0;
      out_data  <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
    end else begin
      if (s2_load) begin
        v2 <= v1;
        if (v1) begin
          out_data  <= d1 << lz1;
          out_shift <= lz1;
          out_zero  <= (lz1 == SW'(WIDTH));
        end
      end
      if (s1_load) begin
        v1 <= in_valid;
        if (in_valid) begin
          d1  <= in_data;
          lz1 <= lz;
        end
      end
    end
  end

endmodule

// File: tb/tb_au_norm_pipe.sv
// Scoreboard bench for au_norm_pipe: directed scenarios on an 8-bit
// instance plus random valid/ready stress on 8/13/32-bit instances.
module tb_au_norm_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  d8;
  logic [12:0] d13;
  logic [31:0] d32;
  logic        rdy8, rdy13, rdy32;
  logic        ov8, ov13, ov32;
  logic        oz8, oz13, oz32;
  logic [7:0]  od8;
  logic [12:0] od13;
  logic [31:0] od32;
  logic [3:0]  os8, os13;
  logic [5:0]  os32;

  au_norm_pipe #(.WIDTH(8), .SW(4), .ARCH(0)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy8), .in_data(d8),
    .out_valid(ov8), .out_ready(out_ready),
    .out_data(od8), .out_shift(os8), .out_zero(oz8)
  );

  au_norm_pipe #(.WIDTH(13), .SW(4), .ARCH(1)) dut13 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy13), .in_data(d13),
    .out_valid(ov13), .out_ready(out_ready),
    .out_data(od13), .out_shift(os13), .out_zero(oz13)
  );

  au_norm_pipe #(.WIDTH(32), .SW(6), .ARCH(2)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy32), .in_data(d32),
    .out_valid(ov32), .out_ready(out_ready),
    .out_data(od32), .out_shift(os32), .out_zero(oz32)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] s;
    logic        z;
  } exp_t;

  exp_t q8[$];
  exp_t q13[$];
  exp_t q32[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic exp_t model(input logic [31:0] x, input int w);
    exp_t e;
    logic [63:0] m;
    logic [63:0] sh;
    int lz;
    lz = w;
    for (int i = 0; i < w; i++) begin
      if (x[i]) lz = w - 1 - i;
    end
    m  = (64'd1 << w) - 64'd1;
    sh = ({32'b0, x} << lz) & m;
    e.d = sh[31:0];
    e.s = 32'(lz);
    e.z = (lz == w);
    return e;
  endfunction

  // Drive one cycle's inputs at negedge; record accepted words.
  task automatic cycle(input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c,
                       input logic r);
    @(negedge clk);
    in_valid  = v;
    d8        = a[7:0];
    d13       = b[12:0];
    d32       = c;
    out_ready = r;
    #1;
    if (in_valid && rdy8)  q8.push_back(model({24'b0, d8}, 8));
    if (in_valid && rdy13) q13.push_back(model({19'b0, d13}, 13));
    if (in_valid && rdy32) q32.push_back(model(d32, 32));
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    q8.delete(); q13.delete(); q32.delete();
    n_cmp++;
    if (ov8 !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b want 0", ov8);
    end
    n_cmp++;
    if (rdy8 !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", rdy8);
    end
    n_cmp++;
    if (od8 !== 8'h00) begin
      n_bad++; $display("FAIL reset_data: got %h want 00", od8);
    end
    n_cmp++;
    if (os8 !== 4'd0) begin
      n_bad++; $display("FAIL reset_shift: got %0d want 0", os8);
    end
    n_cmp++;
    if (oz8 !== 1'b0) begin
      n_bad++; $display("FAIL reset_zero: got %b want 0", oz8);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    cycle(1'b1, 32'h16, 0, 0, 1'b1);
    cycle(1'b0, 0, 0, 0, 1'b1);
    n_cmp++;
    if (ov8 !== 1'b0) begin
      n_bad++; $display("FAIL basic_latency1: got valid %b want 0", ov8);
    end
    cycle(1'b0, 0, 0, 0, 1'b1);
    n_cmp++;
    if (ov8 !== 1'b1) begin
      n_bad++; $display("FAIL basic_latency2: got valid %b want 1", ov8);
    end
    n_cmp++;
    if (od8 !== 8'hB0) begin
      n_bad++; $display("FAIL basic_data: got %h want b0", od8);
    end
    n_cmp++;
    if (os8 !== 4'd3) begin
      n_bad++; $display("FAIL basic_shift: got %0d want 3", os8);
    end
    n_cmp++;
    if (oz8 !== 1'b0) begin
      n_bad++; $display("FAIL basic_zero: got %b want 0", oz8);
    end
    if (q8.size() > 0) e = q8.pop_front();
    cycle(1'b0, 0, 0, 0, 1'b1);
    q13.delete(); q32.delete();
  endtask

  task automatic test_boundary();
    logic [7:0] win [3]  = '{8'h80, 8'h01, 8'h00};
    logic [7:0] wd [3]   = '{8'h80, 8'h80, 8'h00};
    logic [3:0] ws [3]   = '{4'd0, 4'd7, 4'd8};
    logic       wz [3]   = '{1'b0, 1'b0, 1'b1};
    exp_t e;
    int k = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(c < 3, (c < 3) ? {24'b0, win[c]} : 32'b0, 0, 0, 1'b1);
      if (ov8 && k < 3) begin
        n_cmp++;
        if (od8 !== wd[k]) begin
          n_bad++; $display("FAIL bound_data[%0d]: got %h want %h", k, od8, wd[k]);
        end
        n_cmp++;
        if (os8 !== ws[k]) begin
          n_bad++; $display("FAIL bound_shift[%0d]: got %0d want %0d", k, os8, ws[k]);
        end
        n_cmp++;
        if (oz8 !== wz[k]) begin
          n_bad++; $display("FAIL bound_zero[%0d]: got %b want %b", k, oz8, wz[k]);
        end
        if (q8.size() > 0) e = q8.pop_front();
        k++;
      end else if (ov8) begin
        k++;
      end
    end
    n_cmp++;
    if (k != 3) begin
      n_bad++; $display("FAIL bound_count: got %0d want 3", k);
    end
    q13.delete(); q32.delete();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n = 0;
    int first = -1;
    int last = -1;
    for (int c = 0; c < 14; c++) begin
      cycle(c < 8, (c < 8) ? (32'd1 << c) : 32'd0, 0, 0, 1'b1);
      if (ov8) begin
        if (first < 0) first = c;
        last = c;
        n_cmp++;
        if (q8.size() == 0) begin
          n_bad++; $display("FAIL stream_extra: got output %h want none", od8);
        end else begin
          e = q8.pop_front();
          n_cmp++;
          if (od8 !== e.d[7:0]) begin
            n_bad++; $display("FAIL stream_data[%0d]: got %h want %h", n, od8, e.d[7:0]);
          end
          n_cmp++;
          if (os8 !== 4'(7 - n)) begin
            n_bad++; $display("FAIL stream_shift[%0d]: got %0d want %0d", n, os8, 7 - n);
          end
        end
        n_cmp++;
        if (od8 !== 8'h80) begin
          n_bad++; $display("FAIL stream_msb[%0d]: got %h want 80", n, od8);
        end
        n++;
      end
    end
    n_cmp++;
    if (n != 8) begin
      n_bad++; $display("FAIL stream_count: got %0d want 8", n);
    end
    n_cmp++;
    if (last - first != 7) begin
      n_bad++; $display("FAIL stream_gapless: got span %0d want 7", last - first);
    end
    q13.delete(); q32.delete();
  endtask

  task automatic test_backpressure();
    exp_t e;
    int sz0;
    int n = 0;
    logic have = 1'b0;
    logic [7:0] hold = '0;
    sz0 = q8.size();
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 32'h03 << c, 0, 0, 1'b0);
      if (ov8) begin
        if (!have) begin
          hold = od8;
          have = 1'b1;
        end else begin
          n_cmp++;
          if (od8 !== hold) begin
            n_bad++; $display("FAIL bp_stable[%0d]: got %h want %h", c, od8, hold);
          end
        end
      end
    end
    n_cmp++;
    if (rdy8 !== 1'b0) begin
      n_bad++; $display("FAIL bp_ready: got %b want 0", rdy8);
    end
    n_cmp++;
    if (q8.size() - sz0 != 2) begin
      n_bad++; $display("FAIL bp_accepted: got %0d want 2", q8.size() - sz0);
    end
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 0, 0, 0, 1'b1);
      if (ov8) begin
        n_cmp++;
        if (q8.size() == 0) begin
          n_bad++; $display("FAIL bp_extra: got output %h want none", od8);
        end else begin
          e = q8.pop_front();
          n_cmp++;
          if (od8 !== e.d[7:0]) begin
            n_bad++; $display("FAIL bp_data[%0d]: got %h want %h", n, od8, e.d[7:0]);
          end
          n_cmp++;
          if (os8 !== e.s[3:0]) begin
            n_bad++; $display("FAIL bp_shift[%0d]: got %0d want %0d", n, os8, e.s);
          end
        end
        n++;
      end
    end
    n_cmp++;
    if (n != 2) begin
      n_bad++; $display("FAIL bp_released: got %0d want 2", n);
    end
    q13.delete(); q32.delete();
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    cycle(1'b1, 32'h05, 0, 0, 1'b0);
    cycle(1'b1, 32'h09, 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (ov8 !== 1'b1 || rdy8 !== 1'b0) begin
      n_bad++; $display("FAIL rmid_full: got valid %b ready %b want 1 0", ov8, rdy8);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    q8.delete(); q13.delete(); q32.delete();
    n_cmp++;
    if (ov8 !== 1'b0) begin
      n_bad++; $display("FAIL rmid_valid: got %b want 0", ov8);
    end
    n_cmp++;
    if (rdy8 !== 1'b1) begin
      n_bad++; $display("FAIL rmid_ready: got %b want 1", rdy8);
    end
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 0, 0, 0, 1'b1);
      if (ov8) stale++;
    end
    n_cmp++;
    if (stale != 0) begin
      n_bad++; $display("FAIL rmid_stale: got %0d outputs want 0", stale);
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic v, r;
    logic [31:0] a, b, c;
    logic ov, oz;
    logic [31:0] od, os;
    int w;
    int qs;
    q8.delete(); q13.delete(); q32.delete();
    for (int n = 0; n < 3020; n++) begin
      v = (n < 3000) ? 1'($urandom_range(0, 1)) : 1'b0;
      r = (n < 3000) ? ($urandom_range(0, 3) != 0) : 1'b1;
      a = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      b = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      c = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      cycle(v, a, b, c, r);
      for (int k = 0; k < 3; k++) begin
        case (k)
          0: begin
            ov = ov8; od = {24'b0, od8}; os = {28'b0, os8};
            oz = oz8; w = 8; qs = q8.size();
          end
          1: begin
            ov = ov13; od = {19'b0, od13}; os = {28'b0, os13};
            oz = oz13; w = 13; qs = q13.size();
          end
          default: begin
            ov = ov32; od = od32; os = {26'b0, os32};
            oz = oz32; w = 32; qs = q32.size();
          end
        endcase
        if (ov && out_ready) begin
          n_cmp++;
          if (qs == 0) begin
            n_bad++; $display("FAIL rand%0d_extra: got output %h want none", w, od);
          end else begin
            case (k)
              0: e = q8.pop_front();
              1: e = q13.pop_front();
              default: e = q32.pop_front();
            endcase
            n_cmp++;
            if (od !== e.d) begin
              n_bad++; $display("FAIL rand%0d_data: got %h want %h", w, od, e.d);
            end
            n_cmp++;
            if (os !== e.s) begin
              n_bad++; $display("FAIL rand%0d_shift: got %0d want %0d", w, os, e.s);
            end
            n_cmp++;
            if (oz !== e.z) begin
              n_bad++; $display("FAIL rand%0d_zero: got %b want %b", w, oz, e.z);
            end
          end
          n_cmp++;
          if (os > 32'(w)) begin
            n_bad++; $display("FAIL rand%0d_range: got shift %0d want <= %0d", w, os, w);
          end
          if (!oz) begin
            n_cmp++;
            if (od[w-1] !== 1'b1) begin
              n_bad++; $display("FAIL rand%0d_msb: got %h want msb set", w, od);
            end
          end
        end
      end
    end
    n_cmp++;
    if (q8.size() != 0 || q13.size() != 0 || q32.size() != 0) begin
      n_bad++;
      $display("FAIL rand_drain: got left %0d/%0d/%0d want 0/0/0",
               q8.size(), q13.size(), q32.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    d8 = '0;
    d13 = '0;
    d32 = '0;
    test_reset();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
